// File: rtl/seven_seg_pkg.sv
// Shared glyphs, FSM state encodings, segment bit positions and sizing helpers for seven_seg_scan_driver.
`default_nettype none

package seven_seg_pkg;

  // Active-high glyphs, bit order g,f,e,d,c,b,a
  localparam logic [6:0] ZERO  = 7'b0111111;
  localparam logic [6:0] ONE   = 7'b0000110;
  localparam logic [6:0] TWO   = 7'b1011011;
  localparam logic [6:0] THREE = 7'b1001111;
  localparam logic [6:0] FOUR  = 7'b1100110;
  localparam logic [6:0] FIVE  = 7'b1101101;
  localparam logic [6:0] SIX   = 7'b1111101;
  localparam logic [6:0] SEVEN = 7'b0000111;
  localparam logic [6:0] EIGHT = 7'b1111111;
  localparam logic [6:0] NINE  = 7'b1101111;
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] DASH  = 7'b1000000;
  localparam logic [6:0] HEX_A = 7'b1110111;
  localparam logic [6:0] HEX_B = 7'b1111100;
  localparam logic [6:0] HEX_C = 7'b0111001;
  localparam logic [6:0] HEX_D = 7'b1011110;
  localparam logic [6:0] HEX_E = 7'b1111001;
  localparam logic [6:0] HEX_F = 7'b1110001;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Decimal digits needed to hold 2^width-1
  function automatic int dec_digits(input int width);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_glyph_decode.sv
// Nibble to seven-segment glyph decoder; dash overrides blank, blank overrides the digit.
// Hex glyphs A..F are decoded only when SEVEN_SEG_HEX_EN is defined.
`default_nettype none

module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] pattern_o
);

  always_comb begin
    pattern_o = BLANK;
    if (dash_i) begin
      pattern_o = DASH;
    end else if (!blank_i) begin
      case (nibble_i)
        4'd0:    pattern_o = ZERO;
        4'd1:    pattern_o = ONE;
        4'd2:    pattern_o = TWO;
        4'd3:    pattern_o = THREE;
        4'd4:    pattern_o = FOUR;
        4'd5:    pattern_o = FIVE;
        4'd6:    pattern_o = SIX;
        4'd7:    pattern_o = SEVEN;
        4'd8:    pattern_o = EIGHT;
        4'd9:    pattern_o = NINE;
`ifdef SEVEN_SEG_HEX_EN
        4'd10:   pattern_o = HEX_A;
        4'd11:   pattern_o = HEX_B;
        4'd12:   pattern_o = HEX_C;
        4'd13:   pattern_o = HEX_D;
        4'd14:   pattern_o = HEX_E;
        4'd15:   pattern_o = HEX_F;
`endif
        default: pattern_o = BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
// Binary-to-BCD (double-dabble) converter with blanking/overflow and a multiplexed digit scanner.
// Define SEVEN_SEG_HEX_EN to add the hex_mode input for direct hexadecimal display.
`default_nettype none

module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int VALUE_W        = 14,
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  load,
`ifdef SEVEN_SEG_HEX_EN
  input  logic                  hex_mode,
`endif
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  busy,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int DEC_DIGITS = dec_digits(VALUE_W);
  localparam int HEX_DIGITS = (VALUE_W + 3) / 4;
  localparam int ACC_DIGITS = max_int(NUM_DIGITS, max_int(DEC_DIGITS, HEX_DIGITS));
  localparam int ACC_W      = ACC_DIGITS * 4;
  localparam int DISP_W     = NUM_DIGITS * 4;
  localparam int CNT_W      = $clog2(SCAN_DIV);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W      = $clog2(VALUE_W + 1);

  logic [1:0]            state_q, state_d;
  logic [VALUE_W-1:0]    shift_q, shift_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_adj;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DISP_W-1:0]     disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  guard_nz;

  // Nibbles above the visible digits only become nonzero when the value is too wide to show
  if (ACC_W > DISP_W) begin : g_guard
    assign guard_nz = |acc_q[ACC_W-1:DISP_W];
  end else begin : g_no_guard
    assign guard_nz = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    bitcnt_d = bitcnt_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    acc_adj  = acc_q;
    for (int k = 0; k < ACC_DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
`ifdef SEVEN_SEG_HEX_EN
          if (hex_mode) begin
            acc_d                = '0;
            acc_d[VALUE_W-1:0]   = value_in;
            state_d              = COMMIT;
          end else begin
`else
          begin
`endif
            shift_d  = value_in;
            acc_d    = '0;
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d    = {acc_adj[ACC_W-2:0], shift_q[VALUE_W-1]};
        shift_d  = shift_q << 1;
        bitcnt_d = bitcnt_q + BIT_W'(1);
        if (bitcnt_q == BIT_W'(VALUE_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = acc_q[DISP_W-1:0];
        ovf_d   = guard_nz;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [6:0]            cur_pattern;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  // upper_zero[i] is set when digits i..NUM_DIGITS-1 are all zero
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (disp_q[DISP_W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
  end

  assign cur_nib   = disp_q[{idx_q, 2'b00} +: 4];
  assign cur_blank = (idx_q != '0) && upper_zero[idx_q];

  seven_seg_glyph_decode u_decode (
    .nibble_i  (cur_nib),
    .blank_i   (cur_blank),
    .dash_i    (ovf_q),
    .pattern_o (cur_pattern)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    seg_raw                = '0;
    seg_raw[SEG_DP]        = dp_in[idx_q];
    seg_raw[SEG_G:SEG_A]   = cur_pattern;
    for (int i = 0; i < NUM_DIGITS; i++) an_raw[i] = (idx_q == IDX_W'(i));
    seg_d = seg_raw ^ {8{SEG_ACTIVE_LOW}};
    an_d  = an_raw ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      bitcnt_q <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= {8{SEG_ACTIVE_LOW}};
      an_q     <= {NUM_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      bitcnt_q <= bitcnt_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: expected digit slots and busy lengths are queued by the stimulus.
`default_nettype none

module tb_seven_seg_scan_driver;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;
  localparam int SCAN_DIV   = 4;

  localparam logic [6:0] G_ZERO  = 7'h3F;
  localparam logic [6:0] G_ONE   = 7'h06;
  localparam logic [6:0] G_TWO   = 7'h5B;
  localparam logic [6:0] G_THREE = 7'h4F;
  localparam logic [6:0] G_FOUR  = 7'h66;
  localparam logic [6:0] G_SEVEN = 7'h07;
  localparam logic [6:0] G_BLANK = 7'h00;
  localparam logic [6:0] G_DASH  = 7'h40;
  localparam logic [6:0] G_A     = 7'h77;
  localparam logic [6:0] G_F     = 7'h71;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  load;
  logic [VALUE_W-1:0]    value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  busy;
  logic [7:0]            seg_out;
  logic [NUM_DIGITS-1:0] an_out;
`ifdef SEVEN_SEG_HEX_EN
  logic                  hex_mode;
`endif

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (NUM_DIGITS),
    .VALUE_W        (VALUE_W),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .load     (load),
`ifdef SEVEN_SEG_HEX_EN
    .hex_mode (hex_mode),
`endif
    .dp_in    (dp_in),
    .busy     (busy),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    string      name;
  } slot_t;

  slot_t slot_q[$];
  int    busy_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [7:0] pin_seg(input logic dp, input logic [6:0] g);
    return ~{dp, g};
  endfunction

  function automatic logic [3:0] pin_an(input int d);
    logic [3:0] v;
    v    = 4'b1111;
    v[d] = 1'b0;
    return v;
  endfunction

  task automatic expect_slot(input int d, input logic dp, input logic [6:0] g, input string name);
    slot_t s;
    s.an   = pin_an(d);
    s.seg  = pin_seg(dp, g);
    s.name = name;
    slot_q.push_back(s);
  endtask

  task automatic expect_dark(input string name);
    slot_t s;
    s.an   = 4'b1111;
    s.seg  = 8'hFF;
    s.name = name;
    slot_q.push_back(s);
  endtask

  // Monitor: every time a new digit slot appears on the pins, check it against the queue head
  initial begin : slot_monitor
    logic [3:0] prev;
    slot_t      s;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (an_out !== prev) begin
        if (slot_q.size() > 0) begin
          s = slot_q.pop_front();
          n_cmp++;
          if (an_out !== s.an || seg_out !== s.seg) begin
            n_bad++;
            $display("FAIL %s: got an_out=%b seg_out=%h, required an_out=%b seg_out=%h",
                     s.name, an_out, seg_out, s.an, s.seg);
          end
        end
        prev = an_out;
      end
    end
  end

  // Monitor: length of each busy pulse against the queued expectation
  initial begin : busy_monitor
    int run;
    int exp_len;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        exp_len = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
        n_cmp++;
        if (run != exp_len) begin
          n_bad++;
          $display("FAIL busy_len: got %0d cycles, required %0d", run, exp_len);
        end
        run = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic load_value(input logic [VALUE_W-1:0] v, input int busy_len);
    tick();
    busy_q.push_back(busy_len);
    value_in = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) timeout_fail(name);
  endtask

  task automatic sync_last_digit(input string name);
    int k;
    k = 0;
    while (an_out !== 4'b0111 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) timeout_fail(name);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (slot_q.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    if (slot_q.size() > 0) begin
      timeout_fail(name);
      slot_q.delete();
    end
  endtask

  task automatic check_frame(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                             input logic [6:0] g3, input logic [3:0] dp, input string name);
    wait_idle(name);
    sync_last_digit(name);
    expect_slot(0, dp[0], g0, {name, "_d0"});
    expect_slot(1, dp[1], g1, {name, "_d1"});
    expect_slot(2, dp[2], g2, {name, "_d2"});
    expect_slot(3, dp[3], g3, {name, "_d3"});
    drain(name);
  endtask

  initial begin : stimulus
    rst      = 1'b1;
    load     = 1'b0;
    value_in = '0;
    dp_in    = '0;
`ifdef SEVEN_SEG_HEX_EN
    hex_mode = 1'b0;
`endif
    expect_dark("reset");
    repeat (3) tick();
    expect_slot(0, 1'b0, G_ZERO,  "idle_d0");
    expect_slot(1, 1'b0, G_BLANK, "idle_d1");
    expect_slot(2, 1'b0, G_BLANK, "idle_d2");
    expect_slot(3, 1'b0, G_BLANK, "idle_d3");
    rst = 1'b0;
    drain("idle");

    load_value(14'd1234, 15);
    check_frame(G_FOUR, G_THREE, G_TWO, G_ONE, 4'b0000, "v1234");

    load_value(14'd7, 15);
    check_frame(G_SEVEN, G_BLANK, G_BLANK, G_BLANK, 4'b0000, "v7");
    dp_in = 4'b0100;
    check_frame(G_SEVEN, G_BLANK, G_BLANK, G_BLANK, 4'b0100, "v7_dp");
    dp_in = 4'b0000;

    load_value(14'd12000, 15);
    check_frame(G_DASH, G_DASH, G_DASH, G_DASH, 4'b0000, "v12000");

    // 99 arrives while 42 is still converting and must be dropped
    load_value(14'd42, 15);
    tick();
    value_in = 14'd99;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    check_frame(G_TWO, G_FOUR, G_BLANK, G_BLANK, 4'b0000, "v42_drop99");

    load_value(14'd5555, 4);
    repeat (3) tick();
    expect_dark("rst_mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_slot(0, 1'b0, G_ZERO,  "rst_mid_d0");
    expect_slot(1, 1'b0, G_BLANK, "rst_mid_d1");
    expect_slot(2, 1'b0, G_BLANK, "rst_mid_d2");
    expect_slot(3, 1'b0, G_BLANK, "rst_mid_d3");
    drain("rst_mid");

`ifdef SEVEN_SEG_HEX_EN
    tick();
    busy_q.push_back(1);
    value_in = 14'h2AF;
    hex_mode = 1'b1;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    hex_mode = 1'b0;
    check_frame(G_F, G_A, G_TWO, G_BLANK, 4'b0000, "hex2AF");
`endif

    repeat (4) tick();
    if (busy_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_pending: got %0d unmatched busy pulses, required 0", busy_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
